// File: rtl/sevenseg_capture.sv
// Recovers a hex word from a multiplexed active-low seven-segment display bus.
// A digit is accepted once its anode/segment pattern has held steady for DWELL cycles.
module sevenseg_capture #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  seg,
    input  logic        frame_ack,
    output logic [31:0] value,
    output logic [7:0]  digit_valid,
    output logic        frame_valid,
    output logic        bad_pattern
);

    localparam logic [7:0] DWELL_L = 8'(DWELL);

    logic [7:0]  an_q;
    logic [6:0]  seg_q;
    logic [7:0]  run_cnt;
    logic        legal;
    logic        stable;
    logic        capture;
    logic        known;
    logic [3:0]  nibble;
    logic [31:0] value_nxt;
    logic [7:0]  dv_nxt;

    // A capture fires only on the single cycle the run counter crosses into DWELL.
    always_comb begin
        legal   = ($countones(~an_q) == 1);
        stable  = legal && ({an, seg} == {an_q, seg_q});
        capture = stable && (run_cnt == DWELL_L - 8'd1) && !frame_valid;
    end

    always_comb begin
        known  = 1'b1;
        nibble = 4'h0;
        case (seg_q)
            7'b0000001: nibble = 4'h0;
            7'b1001111: nibble = 4'h1;
            7'b0010010: nibble = 4'h2;
            7'b0000110: nibble = 4'h3;
            7'b1001100: nibble = 4'h4;
            7'b0100100: nibble = 4'h5;
            7'b0100000: nibble = 4'h6;
            7'b0001111: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0000100: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b1100000: nibble = 4'hB;
            7'b0110001: nibble = 4'hC;
            7'b1000010: nibble = 4'hD;
            7'b0110000: nibble = 4'hE;
            7'b0111000: nibble = 4'hF;
            default:    known  = 1'b0;
        endcase
    end

    // Exactly one anode bit is low whenever capture is set, so at most one slice changes.
    always_comb begin
        value_nxt = value;
        dv_nxt    = digit_valid;
        if (capture) begin
            for (int i = 0; i < 8; i++) begin
                if (!an_q[i]) begin
                    if (known) begin
                        value_nxt[4*i +: 4] = nibble;
                        dv_nxt[i]           = 1'b1;
                    end else begin
                        dv_nxt[i]           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            run_cnt     <= 8'd0;
            value       <= 32'd0;
            digit_valid <= 8'd0;
            frame_valid <= 1'b0;
            bad_pattern <= 1'b0;
        end else begin
            an_q        <= an;
            seg_q       <= seg;
            value       <= value_nxt;
            bad_pattern <= capture && !known;
            if (stable) begin
                if (run_cnt != DWELL_L)
                    run_cnt <= run_cnt + 8'd1;
            end else begin
                run_cnt <= 8'd0;
            end
            // Capture is already blocked while frame_valid is high, so the ack path never races it.
            if (frame_valid && frame_ack) begin
                frame_valid <= 1'b0;
                digit_valid <= 8'd0;
            end else begin
                digit_valid <= dv_nxt;
                if (!frame_valid && digit_valid == 8'hFF)
                    frame_valid <= 1'b1;
            end
        end
    end

endmodule
